subtractor_4bits_pipeline: RTL and testbench
============================================

// Module: subtractor_4bits_pipeline
// PURPOSE
//   Two-stage pipelined 4-bit subtractor with borrow; the inverse datapath of the
//   4-bit pipelined adder. Computes diff = a - b - bin. Low half resolves in
//   stage 1, high half in stage 2. Drives the adder result checkers in the
//   counter-driven benches: feeding back the adder sum recovers the original operand.
// PARAMETERS
//   WIDTH     4          operand width; must be even
//   LOW_BITS  WIDTH/2    bits resolved in stage 1 (localparam, not overridable)
// PORTS
//   CLK        in   1      system clock, rising edge
//   RST        in   1      asynchronous reset, active low
//   EN         in   1      pipeline advance; 0 = all stages hold (stall)
//   in_valid   in   1      a/b/bin qualify as a new operation this cycle
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   bin        in   1      borrow in
//   diff       out  WIDTH  registered result, (a - b - bin) mod 2^WIDTH
//   bout       out  1      registered borrow out; 1 when a < b + bin (unsigned)
//   out_valid  out  1      diff/bout hold a valid result
//   OV         out  1      signed overflow; present only with SUB_PIPE_OVERFLOW_EN
// BEHAVIOUR
//   - Reset (RST=0, async): all stage registers clear; diff=0, bout=0,
//     out_valid=0, OV=0. Reset mid-operation flushes all in-flight results.
//   - Stage 1, on rising CLK with EN=1: register {b1, d_lo} = a[LOW-1:0] -
//     b[LOW-1:0] - bin, with b1 = the low-half borrow. Also register a and b
//     high halves, and valid1 <= in_valid.
//   - Stage 2, on rising CLK with EN=1: {bout, diff_hi} = a_hi - b_hi - b1.
//     diff <= {diff_hi, d_lo}, out_valid <= valid1.
//   - Latency: exactly 2 enabled clocks from input to diff/bout/out_valid.
//     Throughput: 1 op per enabled cycle. No back-pressure output.
//   - EN=0: every register, including out_valid, holds its value. A stalled
//     result stays visible. Inputs sampled during a stall are ignored.
//   - in_valid=0 with EN=1: data registers still load, so the datapath is
//     free-running. Only the valid bit is qualified, so bubbles propagate as
//     out_valid=0. Checkers must ignore diff whenever out_valid=0.
//   - Arithmetic is unsigned modulo 2^WIDTH with no saturation.
//     Wrap example: 0 - F - 1 = 0 with bout=1.
//   - Reset asserted while EN=0: reset wins.
//   - Reset release coincident with a CLK edge: the first capture occurs on the
//     following edge.
// CONFIGURATION
//   SUB_PIPE_OVERFLOW_EN defined: adds output OV.
//     OV = two's-complement overflow of a - b - bin: operand signs differ and
//     the result sign differs from a's sign. Computed in stage 2 from the
//     registered sign bits; aligned with diff; cleared by reset; held on stall.
//   SUB_PIPE_OVERFLOW_EN undefined: OV port and its logic are absent.
//     All other behaviour is identical.
// TESTING
//   1 Reset: RST=0 for 3 clocks with random inputs -> diff=0, bout=0,
//     out_valid=0 (and OV=0) throughout.
//   2 Basic: EN=1, in_valid=1, a=9, b=3, bin=0 -> 2 clocks later diff=6,
//     bout=0, out_valid=1. Then a=3, b=9 -> diff=A, bout=1.
//   3 Wrap: a=0, b=F, bin=1 -> diff=0, bout=1.
//     Back-to-back ops (5-2, 7-7, 1-2) -> 3, 0, F on consecutive cycles.
//   4 Stall/bubble: with an op in stage 1, drop EN for 2 clocks -> outputs
//     frozen; the result appears 1 enabled clock after EN returns.
//     in_valid=0 for 1 cycle -> a single out_valid=0 slot.
//   5 Sweep: 8-bit counter drives a=cnt[3:0], b=cnt[7:4] with bin alternating,
//     256+ cycles. Compare each output against a model delayed 2 cycles.
//     Adder loop: diff(adder sum, b) == a.
//   6 Mid-op reset + option: pulse RST low between edges with 2 ops in flight
//     -> out_valid=0 immediately; no stale result appears after release.
//     With SUB_PIPE_OVERFLOW_EN: a=7, b=F, bin=0 -> diff=8, OV=1;
//     a=8, b=1 -> diff=7, OV=1; a=5, b=2 -> OV=0.

Source files
------------

// File: rtl/subtractor_4bits_pipeline.sv
// ---------------------------------------------------------------------------
// subtractor_4bits_pipeline
//   Two-stage pipelined subtractor with borrow: diff = a - b - bin.
//   Stage 1 resolves the low half and its borrow. Stage 2 resolves the high
//   half using that borrow. Latency is 2 enabled clocks and throughput is
//   1 op per enabled clock. EN=0 freezes every register, valid included.
//   The datapath is free-running: in_valid only qualifies the valid bit.
//
//   Optional feature macro: SUB_PIPE_OVERFLOW_EN adds the OV output. OV is
//   the signed overflow of a - b - bin, aligned with diff.
//
// Ports
//   CLK        in   1      system clock, rising edge
//   RST        in   1      asynchronous reset, active low
//   EN         in   1      pipeline advance (0 = stall)
//   in_valid   in   1      a/b/bin carry a new operation
//   a          in   WIDTH  minuend, unsigned
//   b          in   WIDTH  subtrahend, unsigned
//   bin        in   1      borrow in
//   diff       out  WIDTH  registered difference
//   bout       out  1      registered borrow out
//   out_valid  out  1      diff/bout hold a valid result
//   OV         out  1      signed overflow (SUB_PIPE_OVERFLOW_EN only)
// ---------------------------------------------------------------------------
module subtractor_4bits_pipeline #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             out_valid
`ifdef SUB_PIPE_OVERFLOW_EN
  ,
  output logic             OV
`endif
);

  localparam int LOW_BITS  = WIDTH / 2;
  localparam int HIGH_BITS = WIDTH - LOW_BITS;

  // Stage 1 state
  logic [LOW_BITS-1:0]  d_lo_q;
  logic                 b1_q;
  logic [HIGH_BITS-1:0] a_hi_q;
  logic [HIGH_BITS-1:0] b_hi_q;
  logic                 valid1_q;

  // Stage 2 state
  logic [WIDTH-1:0]     diff_q;
  logic                 bout_q;
  logic                 valid2_q;

  // One extra bit on each half: it goes to 1 exactly when the half result
  // is negative, so it serves directly as the borrow out.
  logic [LOW_BITS:0]    lo_d;
  logic [HIGH_BITS:0]   hi_d;

  always_comb begin
    lo_d = {1'b0, a[LOW_BITS-1:0]} - {1'b0, b[LOW_BITS-1:0]}
         - {{LOW_BITS{1'b0}}, bin};
  end

  always_comb begin
    hi_d = {1'b0, a_hi_q} - {1'b0, b_hi_q} - {{HIGH_BITS{1'b0}}, b1_q};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      d_lo_q   <= '0;
      b1_q     <= 1'b0;
      a_hi_q   <= '0;
      b_hi_q   <= '0;
      valid1_q <= 1'b0;
    end else if (EN) begin
      d_lo_q   <= lo_d[LOW_BITS-1:0];
      b1_q     <= lo_d[LOW_BITS];
      a_hi_q   <= a[WIDTH-1:LOW_BITS];
      b_hi_q   <= b[WIDTH-1:LOW_BITS];
      valid1_q <= in_valid;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      diff_q   <= '0;
      bout_q   <= 1'b0;
      valid2_q <= 1'b0;
    end else if (EN) begin
      diff_q   <= {hi_d[HIGH_BITS-1:0], d_lo_q};
      bout_q   <= hi_d[HIGH_BITS];
      valid2_q <= valid1_q;
    end
  end

  assign diff      = diff_q;
  assign bout      = bout_q;
  assign out_valid = valid2_q;

`ifdef SUB_PIPE_OVERFLOW_EN
  logic ov_q;
  logic ov_d;

  // The operand sign bits live in the registered high halves. The result
  // sign is the top bit of the stage-2 high half.
  always_comb begin
    ov_d = (a_hi_q[HIGH_BITS-1] != b_hi_q[HIGH_BITS-1]) &&
           (hi_d[HIGH_BITS-1] != a_hi_q[HIGH_BITS-1]);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ov_q <= 1'b0;
    end else if (EN) begin
      ov_q <= ov_d;
    end
  end

  assign OV = ov_q;
`endif

endmodule

// File: tb/tb_subtractor_4bits_pipeline.sv
module tb_subtractor_4bits_pipeline;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       bin;
  logic [3:0] diff;
  logic       bout;
  logic       out_valid;
`ifdef SUB_PIPE_OVERFLOW_EN
  logic       ov;
`endif

  subtractor_4bits_pipeline #(.WIDTH(4)) dut (
    .CLK       (clk),
    .RST       (rst_n),
    .EN        (en),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .diff      (diff),
    .bout      (bout),
    .out_valid (out_valid)
`ifdef SUB_PIPE_OVERFLOW_EN
    ,
    .OV        (ov)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  d;
    logic        bo;
    logic        ov;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned en_cnt   = 0;
  logic        last_valid = 1'b0;
  logic [3:0]  last_diff  = '0;
  logic        last_bout  = 1'b0;
  logic        last_ov    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. ovr >= 0 replaces the modelled difference; the adder
  // loop uses it to demand the original operand back.
  function automatic exp_t model(input logic [3:0] ma, input logic [3:0] mb,
                                 input logic mbin, input int ovr);
    exp_t e;
    int   full;
    full = int'(ma) - int'(mb) - int'(mbin);
    e.d  = (ovr >= 0) ? 4'(ovr) : 4'(full & 15);
    e.bo = (full < 0);
    e.ov = (ma[3] != mb[3]) && (4'(full & 15) >> 3 != {3'b0, ma[3]});
    e.due = 0;
    return e;
  endfunction

  task automatic check_outputs();
    if (!rst_n) begin
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_diff",  32'(diff),      32'd0);
      check("rst_bout",  32'(bout),      32'd0);
`ifdef SUB_PIPE_OVERFLOW_EN
      check("rst_ov",    32'(ov),        32'd0);
`endif
    end else begin
      check("valid", 32'(out_valid), 32'(last_valid));
      if (last_valid) begin
        check("diff", 32'(diff), 32'(last_diff));
        check("bout", 32'(bout), 32'(last_bout));
`ifdef SUB_PIPE_OVERFLOW_EN
        check("ov",   32'(ov),   32'(last_ov));
`endif
      end
    end
  endtask

  // Drive one cycle, clock it, update the scoreboard and check outputs.
  task automatic step(input logic s_en, input logic s_iv, input logic [3:0] s_a,
                      input logic [3:0] s_b, input logic s_bin, input int ovr);
    exp_t e;
    en = s_en; in_valid = s_iv; a = s_a; b = s_b; bin = s_bin;
    e = model(s_a, s_b, s_bin, ovr);
    @(posedge clk);
    if (!rst_n) begin
      last_valid = 1'b0;
    end else if (s_en) begin
      en_cnt++;
      if (s_iv) begin
        e.due = en_cnt + 1;
        sb.push_back(e);
      end
      if (sb.size() > 0 && sb[0].due == en_cnt) begin
        last_valid = 1'b1;
        last_diff  = sb[0].d;
        last_bout  = sb[0].bo;
        last_ov    = sb[0].ov;
        void'(sb.pop_front());
      end else begin
        last_valid = 1'b0;
      end
    end
    #1;
    check_outputs();
  endtask

  task automatic op(input logic [3:0] oa, input logic [3:0] ob, input logic obin);
    step(1'b1, 1'b1, oa, ob, obin, -1);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 4'($urandom), 4'($urandom), 1'($urandom), -1);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0;
    #1;
    check_outputs();

    // Reset held with random inputs
    for (int i = 0; i < 3; i++)
      step(1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), -1);
    rst_n = 1'b1;

    // Basic
    op(4'h9, 4'h3, 1'b0);
    op(4'h3, 4'h9, 1'b0);
    // Wrap and back-to-back
    op(4'h0, 4'hF, 1'b1);
    op(4'h5, 4'h2, 1'b0);
    op(4'h7, 4'h7, 1'b0);
    op(4'h1, 4'h2, 1'b0);
    idle(); idle();

    // Stall with an op in stage 1; inputs during the stall are ignored
    op(4'hC, 4'h4, 1'b1);
    step(1'b0, 1'b1, 4'hF, 4'h1, 1'b0, -1);
    step(1'b0, 1'b1, 4'h2, 4'hE, 1'b1, -1);
    idle();
    // Stall with a result visible at the output
    op(4'h6, 4'h1, 1'b0);
    op(4'hA, 4'h5, 1'b0);
    step(1'b0, 1'b1, 4'h3, 4'h3, 1'b0, -1);
    step(1'b0, 1'b0, 4'h3, 4'h3, 1'b0, -1);
    // Single bubble
    op(4'h8, 4'h2, 1'b0);
    idle();
    op(4'h4, 4'h4, 1'b1);
    idle(); idle();

    // Counter sweep
    for (int c = 0; c < 260; c++) begin
      logic [7:0] cnt;
      cnt = 8'(c);
      op(cnt[3:0], cnt[7:4], cnt[0]);
    end
    idle(); idle();

    // Adder loop: subtracting b from the adder sum returns a
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++)
        step(1'b1, 1'b1, 4'(x + y), 4'(y), 1'b0, x);
    idle(); idle();

    // Mid-op reset between edges flushes everything in flight
    op(4'h9, 4'h1, 1'b0);
    op(4'hB, 4'h2, 1'b0);
    op(4'hD, 4'h3, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs();
    rst_n = 1'b1;
    sb.delete();
    last_valid = 1'b0;
    idle(); idle(); idle();

`ifdef SUB_PIPE_OVERFLOW_EN
    op(4'h7, 4'hF, 1'b0);
    op(4'h8, 4'h1, 1'b0);
    op(4'h5, 4'h2, 1'b0);
    idle(); idle();
`endif

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
